// File: rtl/mips_decode_execute_pkg.sv
// Shared encodings for the MIPS decode/execute slice: opcodes, R-type
// function codes, ALU operation selects and branch kinds.
package mips_decode_execute_pkg;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instruction[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Branch kinds
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;

    // ALU operation selects
    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_SLT   = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_LUI   = 4'b0110,
        ALU_RTYPE = 4'b1111
    } alu_op_e;

    // Sign-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_alu.sv
// ALU with HI/LO multiply/divide result registers.
module mips_alu
    import mips_decode_execute_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] rt_data,
    input  logic [15:0] imm,
    input  logic [4:0]  shamt,
    input  logic [5:0]  func,
    input  logic [3:0]  alu_op,
    input  logic        alu_src,
    output logic [31:0] result,
    output logic        no_gpr_write,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] op_b_s;
    logic [31:0] zimm_s;
    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic        is_mult_s;
    logic        is_div_s;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    // Operand selection and wide multiply/divide results
    always_comb begin
        if (alu_src) begin
            op_b_s = sign_ext16(imm);
        end else begin
            op_b_s = rt_data;
        end
        zimm_s = {16'h0000, imm};
        // Sign-extended operands make the low 64 bits of the product signed-correct
        prod_s = {{32{a[31]}}, a} * {{32{op_b_s[31]}}, op_b_s};
        if (op_b_s != 32'h0000_0000) begin
            quot_s = $signed(a) / $signed(op_b_s);
            rem_s  = $signed(a) % $signed(op_b_s);
        end else begin
            quot_s = 32'h0000_0000;
            rem_s  = 32'h0000_0000;
        end
        is_mult_s = (alu_op == ALU_RTYPE) && (func == FN_MULT);
        is_div_s  = (alu_op == ALU_RTYPE) && (func == FN_DIV);
    end

    // Result selection; HI/LO traffic never writes a GPR
    always_comb begin
        result       = 32'h0000_0000;
        no_gpr_write = 1'b0;
        case (alu_op)
            ALU_ADD: result = a + op_b_s;
            ALU_SUB: result = a - op_b_s;
            ALU_AND: result = a & zimm_s;
            ALU_OR:  result = a | zimm_s;
            ALU_XOR: result = a ^ zimm_s;
            ALU_SLT: result = {31'h0000_0000, ($signed(a) < $signed(op_b_s))};
            ALU_LUI: result = {imm, 16'h0000};
            ALU_RTYPE: begin
                case (func)
                    FN_ADD:  result = a + op_b_s;
                    FN_SUB:  result = a - op_b_s;
                    FN_AND:  result = a & op_b_s;
                    FN_OR:   result = a | op_b_s;
                    FN_XOR:  result = a ^ op_b_s;
                    FN_NOR:  result = ~(a | op_b_s);
                    FN_SLT:  result = {31'h0000_0000, ($signed(a) < $signed(op_b_s))};
                    FN_SLL:  result = op_b_s << shamt;
                    FN_SRL:  result = op_b_s >> shamt;
                    FN_MFHI: begin
                        result       = hi_r;
                        no_gpr_write = 1'b1;
                    end
                    FN_MFLO: begin
                        result       = lo_r;
                        no_gpr_write = 1'b1;
                    end
                    FN_MULT, FN_DIV: begin
                        result       = 32'h0000_0000;
                        no_gpr_write = 1'b1;
                    end
                    default: result = 32'h0000_0000;
                endcase
            end
            default: result = 32'h0000_0000;
        endcase
    end

    // HI/LO update; a zero divisor leaves both registers untouched
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_r <= 32'h0000_0000;
            lo_r <= 32'h0000_0000;
        end else if (is_mult_s) begin
            hi_r <= prod_s[63:32];
            lo_r <= prod_s[31:0];
        end else if (is_div_s && (op_b_s != 32'h0000_0000)) begin
            hi_r <= rem_s;
            lo_r <= quot_s;
        end
    end

    assign hi = hi_r;
    assign lo = lo_r;

endmodule

// File: rtl/mips_control.sv
// Main controller: decodes the primary opcode into datapath controls.
// All controls are forced low while reset is asserted.
module mips_control
    import mips_decode_execute_pkg::*;
(
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       reg_dst,
    output logic       alu_src,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_to_reg,
    output logic       mem_write,
    output logic       jump,
    output logic [1:0] branch,
    output logic [3:0] alu_op
);

    // Opcode decode; unknown opcodes behave as a NOP
    always_comb begin
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = BR_NONE;
        alu_op     = ALU_ADD;
        if (!reset) begin
            branch = BR_NONE;
        end else begin
            case (opcode)
                OP_RTYPE: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    alu_op    = ALU_RTYPE;
                end
                OP_LW: begin
                    alu_src    = 1'b1;
                    mem_read   = 1'b1;
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    alu_op     = ALU_ADD;
                end
                OP_SW: begin
                    alu_src   = 1'b1;
                    mem_write = 1'b1;
                    alu_op    = ALU_ADD;
                end
                OP_BEQ: begin
                    branch = BR_EQ;
                    alu_op = ALU_SUB;
                end
                OP_BNE: begin
                    branch = BR_NE;
                    alu_op = ALU_SUB;
                end
                OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: begin
                    alu_src   = 1'b1;
                    reg_write = 1'b1;
                    case (opcode)
                        OP_ANDI: alu_op = ALU_AND;
                        OP_ORI:  alu_op = ALU_OR;
                        OP_XORI: alu_op = ALU_XOR;
                        OP_SLTI: alu_op = ALU_SLT;
                        OP_LUI:  alu_op = ALU_LUI;
                        default: alu_op = ALU_ADD;
                    endcase
                end
                OP_J: begin
                    jump = 1'b1;
                end
                default: begin
                    jump = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file, two combinational read ports and
// one write port. Register 0 is hard-wired to zero.
module mips_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  waddr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] regs [0:31]
);

    logic [31:0] regs_r [0:31];

    // Read ports; a same-cycle write is not bypassed, so old data is seen
    always_comb begin
        if (rs == 5'd0) begin
            rdata0 = 32'h0000_0000;
        end else begin
            rdata0 = regs_r[rs];
        end
        if (rt == 5'd0) begin
            rdata1 = 32'h0000_0000;
        end else begin
            rdata1 = regs_r[rt];
        end
    end

    // Debug view of every register, with register 0 pinned to zero
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            if (i == 0) begin
                regs[i] = 32'h0000_0000;
            end else begin
                regs[i] = regs_r[i];
            end
        end
    end

    // Register storage: reset clears all, writes to register 0 are dropped
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_r[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/mips_decode_execute.sv
// Single-cycle MIPS decode/execute slice: controller, register file and
// ALU with HI/LO, sitting between fetch and memory/write-back.
module mips_decode_execute
    import mips_decode_execute_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] writeData,
    output logic        jump,
    output logic [1:0]  branch,
    output logic        memRead,
    output logic        memToReg,
    output logic        memWrite,
    output logic [31:0] readRegister0,
    output logic [31:0] readRegister1,
    output logic [31:0] immediateExtended,
    output logic [31:0] resultOutput,
    output logic        isAluOutputZero,
    output logic [31:0] ioRegisters [0:31],
    output logic [31:0] ioHiLo [0:1]
);

    logic       reg_dst_s;
    logic       alu_src_s;
    logic       reg_write_s;
    logic [3:0] alu_op_s;
    logic       no_gpr_write_s;
    logic       gpr_we_s;
    logic [4:0] waddr_s;
    logic [31:0] hi_s;
    logic [31:0] lo_s;

    mips_control u_control (
        .reset      (reset),
        .opcode     (instruction[31:26]),
        .reg_dst    (reg_dst_s),
        .alu_src    (alu_src_s),
        .reg_write  (reg_write_s),
        .mem_read   (memRead),
        .mem_to_reg (memToReg),
        .mem_write  (memWrite),
        .jump       (jump),
        .branch     (branch),
        .alu_op     (alu_op_s)
    );

    // Write-port steering: destination select and HI/LO write suppression
    always_comb begin
        if (reg_dst_s) begin
            waddr_s = instruction[15:11];
        end else begin
            waddr_s = instruction[20:16];
        end
        gpr_we_s = reg_write_s && !no_gpr_write_s;
    end

    mips_regfile u_regfile (
        .clk    (clk),
        .reset  (reset),
        .rs     (instruction[25:21]),
        .rt     (instruction[20:16]),
        .waddr  (waddr_s),
        .we     (gpr_we_s),
        .wdata  (writeData),
        .rdata0 (readRegister0),
        .rdata1 (readRegister1),
        .regs   (ioRegisters)
    );

    mips_alu u_alu (
        .clk          (clk),
        .reset        (reset),
        .a            (readRegister0),
        .rt_data      (readRegister1),
        .imm          (instruction[15:0]),
        .shamt        (instruction[10:6]),
        .func         (instruction[5:0]),
        .alu_op       (alu_op_s),
        .alu_src      (alu_src_s),
        .result       (resultOutput),
        .no_gpr_write (no_gpr_write_s),
        .hi           (hi_s),
        .lo           (lo_s)
    );

    // Immediate, zero flag and HI/LO debug view
    always_comb begin
        immediateExtended = sign_ext16(instruction[15:0]);
        isAluOutputZero   = (resultOutput == 32'h0000_0000);
        ioHiLo[0]         = hi_s;
        ioHiLo[1]         = lo_s;
    end

endmodule

// File: tb/tb_mips_decode_execute.sv
// Self-checking bench for mips_decode_execute: directed scenarios followed
// by randomized instructions checked against an instruction-level model.
module tb_mips_decode_execute;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] writeData;
    logic        jump;
    logic [1:0]  branch;
    logic        memRead;
    logic        memToReg;
    logic        memWrite;
    logic [31:0] readRegister0;
    logic [31:0] readRegister1;
    logic [31:0] immediateExtended;
    logic [31:0] resultOutput;
    logic        isAluOutputZero;
    logic [31:0] io_regs [0:31];
    logic [31:0] io_hilo [0:1];

    mips_decode_execute dut (
        .clk               (clk),
        .reset             (reset),
        .instruction       (instruction),
        .writeData         (writeData),
        .jump              (jump),
        .branch            (branch),
        .memRead           (memRead),
        .memToReg          (memToReg),
        .memWrite          (memWrite),
        .readRegister0     (readRegister0),
        .readRegister1     (readRegister1),
        .immediateExtended (immediateExtended),
        .resultOutput      (resultOutput),
        .isAluOutputZero   (isAluOutputZero),
        .ioRegisters       (io_regs),
        .ioHiLo            (io_hilo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural model state
    logic [31:0] gpr [0:31];
    logic [31:0] m_hi, m_lo;

    // Model predictions for the current instruction
    logic        e_jump, e_mr, e_mtr, e_mw, e_we, e_mult, e_div;
    logic [1:0]  e_br;
    logic [31:0] e_res, e_a, e_b;
    logic [4:0]  e_wa;

    // Snapshot of the last step's outputs for directed checks
    logic [1:0]  last_br;
    logic        last_zero, last_mr, last_mtr, last_mw, last_jump;
    logic [31:0] last_res;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Instruction-level semantics of one instruction against the model state
    task automatic predict(input logic [31:0] ins);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [31:0] se, ze;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        rd = ins[15:11]; sh = ins[10:6]; fn = ins[5:0]; imm = ins[15:0];
        se = {{16{imm[15]}}, imm};
        ze = {16'h0000, imm};
        e_a = gpr[rs]; e_b = gpr[rt];
        e_jump = 1'b0; e_br = 2'd0; e_mr = 1'b0; e_mtr = 1'b0; e_mw = 1'b0;
        e_we = 1'b0; e_wa = rt; e_mult = 1'b0; e_div = 1'b0;
        e_res = e_a + e_b;
        if (reset) begin
            case (op)
                6'h00: begin
                    e_we = 1'b1; e_wa = rd;
                    case (fn)
                        6'h20: e_res = e_a + e_b;
                        6'h22: e_res = e_a - e_b;
                        6'h24: e_res = e_a & e_b;
                        6'h25: e_res = e_a | e_b;
                        6'h26: e_res = e_a ^ e_b;
                        6'h27: e_res = ~(e_a | e_b);
                        6'h2A: e_res = ($signed(e_a) < $signed(e_b)) ? 32'd1 : 32'd0;
                        6'h00: e_res = e_b << sh;
                        6'h02: e_res = e_b >> sh;
                        6'h10: begin e_res = m_hi; e_we = 1'b0; end
                        6'h12: begin e_res = m_lo; e_we = 1'b0; end
                        6'h18: begin e_res = 32'd0; e_we = 1'b0; e_mult = 1'b1; end
                        6'h1A: begin e_res = 32'd0; e_we = 1'b0; e_div = 1'b1; end
                        default: e_res = 32'd0;
                    endcase
                end
                6'h23: begin e_mr = 1'b1; e_mtr = 1'b1; e_we = 1'b1; e_res = e_a + se; end
                6'h2B: begin e_mw = 1'b1; e_res = e_a + se; end
                6'h04: begin e_br = 2'd1; e_res = e_a - e_b; end
                6'h05: begin e_br = 2'd2; e_res = e_a - e_b; end
                6'h08: begin e_we = 1'b1; e_res = e_a + se; end
                6'h0C: begin e_we = 1'b1; e_res = e_a & ze; end
                6'h0D: begin e_we = 1'b1; e_res = e_a | ze; end
                6'h0E: begin e_we = 1'b1; e_res = e_a ^ ze; end
                6'h0A: begin e_we = 1'b1; e_res = ($signed(e_a) < $signed(se)) ? 32'd1 : 32'd0; end
                6'h0F: begin e_we = 1'b1; e_res = {imm, 16'h0000}; end
                6'h02: e_jump = 1'b1;
                default: e_res = e_a + e_b;
            endcase
        end
    endtask

    // Apply the clock edge to the model
    task automatic commit(input logic [31:0] wd);
        longint p;
        int     q, r;
        if (!reset) begin
            for (int i = 0; i < 32; i++) gpr[i] = 32'd0;
            m_hi = 32'd0; m_lo = 32'd0;
        end else begin
            if (e_we && e_wa != 5'd0) gpr[e_wa] = wd;
            if (e_mult) begin
                p = longint'($signed(e_a)) * longint'($signed(e_b));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            if (e_div && e_b != 32'd0) begin
                q = $signed(e_a) / $signed(e_b);
                r = $signed(e_a) % $signed(e_b);
                m_lo = q; m_hi = r;
            end
        end
    endtask

    // One instruction: check combinational outputs mid-cycle, then state after the edge
    task automatic step(input logic [31:0] ins, input logic [31:0] wd);
        instruction = ins;
        writeData   = wd;
        @(negedge clk);
        predict(ins);
        check("jump",     {31'd0, jump},     {31'd0, e_jump});
        check("branch",   {30'd0, branch},   {30'd0, e_br});
        check("memRead",  {31'd0, memRead},  {31'd0, e_mr});
        check("memToReg", {31'd0, memToReg}, {31'd0, e_mtr});
        check("memWrite", {31'd0, memWrite}, {31'd0, e_mw});
        if (reset) begin
            check("rdReg0", readRegister0, e_a);
            check("rdReg1", readRegister1, e_b);
            check("immExt", immediateExtended, {{16{ins[15]}}, ins[15:0]});
            check("result", resultOutput, e_res);
            check("zero", {31'd0, isAluOutputZero}, {31'd0, (e_res == 32'd0)});
        end
        last_br = branch; last_zero = isAluOutputZero; last_res = resultOutput;
        last_mr = memRead; last_mtr = memToReg; last_mw = memWrite; last_jump = jump;
        @(posedge clk);
        commit(wd);
        #1;
        for (int i = 0; i < 32; i++) check($sformatf("gpr%0d", i), io_regs[i], gpr[i]);
        check("hi", io_hilo[0], m_hi);
        check("lo", io_hilo[1], m_lo);
    endtask

    logic [5:0] fns  [14] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                              6'h00, 6'h02, 6'h10, 6'h12, 6'h18, 6'h1A, 6'h3F};
    logic [5:0] iops [10] = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D,
                              6'h0E, 6'h0A, 6'h0F};

    initial begin
        logic [31:0] ins;
        int k;
        for (int i = 0; i < 32; i++) gpr[i] = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        instruction = 32'd0; writeData = 32'd0;

        // Reset with a jump presented: controls must stay low
        reset = 1'b0;
        step({6'h02, 26'd0}, 32'hDEAD_BEEF);
        check("rst_jump", {31'd0, last_jump}, 32'd0);
        check("rst_hi", io_hilo[0], 32'd0);
        check("rst_r31", io_regs[31], 32'd0);
        reset = 1'b1;

        step(enc_i(6'h08, 5'd0, 5'd1, 16'd5), 32'd5);
        step(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD), 32'hFFFF_FFFD);
        step(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd2);
        check("add_res", last_res, 32'd2);
        check("add_r3", io_regs[3], 32'd2);
        step(enc_r(5'd1, 5'd1, 5'd4, 5'd0, 6'h22), 32'd0);
        check("sub_zero", {31'd0, last_zero}, 32'd1);
        step(enc_i(6'h04, 5'd1, 5'd1, 16'd4), 32'd0);
        check("beq_br", {30'd0, last_br}, 32'd1);
        check("beq_zero", {31'd0, last_zero}, 32'd1);
        step(enc_i(6'h05, 5'd1, 5'd2, 16'd4), 32'd0);
        check("bne_br", {30'd0, last_br}, 32'd2);
        step(enc_r(5'd1, 5'd2, 5'd0, 5'd0, 6'h18), 32'd0);
        check("mult_hi", io_hilo[0], 32'hFFFF_FFFF);
        check("mult_lo", io_hilo[1], 32'hFFFF_FFF1);
        step(enc_r(5'd0, 5'd0, 5'd5, 5'd0, 6'h12), 32'h1234_5678);
        check("mflo_res", last_res, 32'hFFFF_FFF1);
        check("mflo_nowr", io_regs[5], 32'd0);
        step(enc_i(6'h08, 5'd0, 5'd7, 16'd7), 32'd7);
        step(enc_i(6'h08, 5'd0, 5'd8, 16'd2), 32'd2);
        step(enc_r(5'd7, 5'd8, 5'd0, 5'd0, 6'h1A), 32'd0);
        check("div_lo", io_hilo[1], 32'd3);
        check("div_hi", io_hilo[0], 32'd1);
        step(enc_r(5'd7, 5'd0, 5'd0, 5'd0, 6'h1A), 32'd0);
        check("div0_lo", io_hilo[1], 32'd3);
        check("div0_hi", io_hilo[0], 32'd1);
        step(enc_i(6'h23, 5'd1, 5'd6, 16'd8), 32'hCAFE_F00D);
        check("lw_mr", {31'd0, last_mr}, 32'd1);
        check("lw_mtr", {31'd0, last_mtr}, 32'd1);
        check("lw_addr", last_res, 32'd13);
        check("lw_r6", io_regs[6], 32'hCAFE_F00D);
        step(enc_i(6'h2B, 5'd1, 5'd3, 16'd4), 32'h5555_AAAA);
        check("sw_mw", {31'd0, last_mw}, 32'd1);
        check("sw_r3", io_regs[3], 32'd2);
        step(enc_i(6'h08, 5'd0, 5'd0, 16'd7), 32'd7);
        check("r0_zero", io_regs[0], 32'd0);
        step({6'h3F, 26'h3FF_FFFF}, 32'h0BAD_0BAD);
        check("nop_ctl", {26'd0, last_jump, last_br, last_mr, last_mtr, last_mw}, 32'd0);

        // Randomized instruction stream, with one mid-run reset
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 19);
            if (k < 8) begin
                ins = enc_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                            fns[$urandom_range(0, 13)]);
            end else if (k < 18) begin
                ins = enc_i(iops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 16'($urandom));
            end else if (k == 18) begin
                ins = {6'h02, 26'($urandom)};
            end else begin
                ins = $urandom;
            end
            // Keep clear of the unrepresentable most-negative / -1 quotient
            if (ins[31:26] == 6'h00 && ins[5:0] == 6'h1A &&
                gpr[ins[25:21]] == 32'h8000_0000 && gpr[ins[20:16]] == 32'hFFFF_FFFF) begin
                ins[5:0] = 6'h20;
            end
            if (n == 200) reset = 1'b0;
            step(ins, $urandom);
            reset = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
